// File: rtl/cnn_batch_norm_ch.sv
// Per-channel batch normalization: out = pxl * gamma[ch] + beta[ch], optional fused ReLU.
// Coefficients load once after reset (LOAD), then a channel-major pixel stream runs (RUN).
module cnn_batch_norm_ch #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CHANNEL_NUM   = 64,
    parameter int unsigned PIXELS_PER_CH = 1024,
    parameter int unsigned MUL_LAT       = 1,
    parameter int unsigned ADD_LAT       = 1,
    parameter bit          RELU_EN       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  valid_out,
    output logic                  coef_ready,
    output logic                  frame_done
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned EW    = (DW == 64) ? 11 : ((DW == 16) ? 5 : 8);
    localparam int unsigned MW    = DW - EW - 1;
    localparam int unsigned PW    = 2 * (MW + 1);
    localparam int unsigned SW    = MW + 4;
    localparam int unsigned LZW   = $clog2(SW + 1);
    localparam int unsigned BIAS  = (1 << (EW - 1)) - 1;
    localparam int unsigned CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int unsigned PIX_W = (PIXELS_PER_CH > 1) ? $clog2(PIXELS_PER_CH) : 1;
    localparam int unsigned PTR_W = $clog2(CHANNEL_NUM + 1);
    localparam logic [DW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    // fp_mul unit: round-to-nearest-even, denormals flushed to zero
    function automatic logic [DW-1:0] fp_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic            sign;
        logic [EW-1:0]   ea, eb;
        logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [PW-1:0]   prod;
        logic [PW-2:0]   norm;
        logic            rnd_up;
        logic [MW:0]     frac_r;
        logic [EW+1:0]   exp;
        logic            ovf, unf;
        logic [DW-1:0]   res;
        sign   = a[DW-1] ^ b[DW-1];
        ea     = a[DW-2 -: EW];
        eb     = b[DW-2 -: EW];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (a[MW-1:0] == '0);
        b_inf  = (&eb) && (b[MW-1:0] == '0);
        a_nan  = (&ea) && (a[MW-1:0] != '0);
        b_nan  = (&eb) && (b[MW-1:0] != '0);
        prod   = PW'({1'b1, a[MW-1:0]}) * PW'({1'b1, b[MW-1:0]});
        norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        rnd_up = norm[PW-2-MW] & ((|norm[PW-3-MW:0]) | norm[PW-1-MW]);
        frac_r = {1'b0, norm[PW-2 -: MW]} + (MW+1)'(rnd_up);
        exp    = (EW+2)'(ea) + (EW+2)'(eb) + (EW+2)'(prod[PW-1])
               + (EW+2)'(frac_r[MW]) - (EW+2)'(BIAS);
        ovf    = ~exp[EW+1] & (exp[EW] | (&exp[EW-1:0]));
        unf    = exp[EW+1] | (exp == '0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = QNAN;
        else if (a_inf || b_inf)   res = {sign, {EW{1'b1}}, {MW{1'b0}}};
        else if (a_zero || b_zero) res = {sign, {(DW-1){1'b0}}};
        else if (ovf)              res = {sign, {EW{1'b1}}, {MW{1'b0}}};
        else if (unf)              res = {sign, {(DW-1){1'b0}}};
        else                       res = {sign, exp[EW-1:0], frac_r[MW-1:0]};
        return res;
    endfunction

    // fp_add unit: align, add/sub, normalize, round-to-nearest-even
    function automatic logic [DW-1:0] fp_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic            swap, sub;
        logic [DW-1:0]   x, y;
        logic [EW-1:0]   ex, ey, d;
        logic [SW-1:0]   mx, my, my_al, nrm;
        logic [SW:0]     sum;
        logic [LZW-1:0]  lz;
        logic            up, x_inf, y_inf, x_nan, ovf, unf;
        logic [MW:0]     frac_r;
        logic [EW+1:0]   exp;
        logic [DW-1:0]   res;
        swap  = b[DW-2:0] > a[DW-2:0];
        x     = swap ? b : a;
        y     = swap ? a : b;
        ex    = x[DW-2 -: EW];
        ey    = y[DW-2 -: EW];
        d     = ex - ey;
        x_inf = (&ex) && (x[MW-1:0] == '0);
        x_nan = (&ex) && (x[MW-1:0] != '0);
        y_inf = (&ey) && (y[MW-1:0] == '0);
        sub   = x[DW-1] ^ y[DW-1];
        mx    = {1'b1, x[MW-1:0], 3'b000};
        my    = {1'b1, y[MW-1:0], 3'b000};
        my_al = (my >> d) | SW'(|(my & ~({SW{1'b1}} << d)));
        sum   = sub ? ({1'b0, mx} - {1'b0, my_al}) : ({1'b0, mx} + {1'b0, my_al});
        lz    = LZW'(SW);
        for (int i = 0; i < int'(SW); i++) begin
            if (sum[i]) lz = LZW'(int'(SW) - 1 - i);
        end
        if (sum[SW]) begin
            nrm = {sum[SW:2], sum[1] | sum[0]};
            exp = (EW+2)'(ex) + (EW+2)'(1);
        end else begin
            nrm = sum[SW-1:0] << lz;
            exp = (EW+2)'(ex) - (EW+2)'(lz);
        end
        up     = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        frac_r = {1'b0, nrm[SW-2:3]} + (MW+1)'(up);
        exp    = exp + (EW+2)'(frac_r[MW]);
        ovf    = ~exp[EW+1] & (exp[EW] | (&exp[EW-1:0]));
        unf    = exp[EW+1] | (exp == '0);
        if (x_nan || (x_inf && y_inf && sub)) res = QNAN;
        else if (x_inf)        res = {x[DW-1], {EW{1'b1}}, {MW{1'b0}}};
        else if (ex == '0)     res = {x[DW-1] & y[DW-1], {(DW-1){1'b0}}};
        else if (ey == '0)     res = x;
        else if (~nrm[SW-1])   res = '0;
        else if (ovf)          res = {x[DW-1], {EW{1'b1}}, {MW{1'b0}}};
        else if (unf)          res = {x[DW-1], {(DW-1){1'b0}}};
        else                   res = {x[DW-1], exp[EW-1:0], frac_r[MW-1:0]};
        return res;
    endfunction

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_wptr, r_bptr;
    logic [CH_W-1:0]    r_ch_cnt;
    logic [PIX_W-1:0]   r_pix_cnt;
    logic [DW-1:0]      r_gamma [CHANNEL_NUM];
    logic [DW-1:0]      r_beta  [CHANNEL_NUM];

    logic [DW-1:0]      r_s0_pxl, r_s0_gamma, r_s0_beta;
    logic               r_s0_valid, r_s0_last;
    logic [DW-1:0]      r_mul_pipe [MUL_LAT];
    logic [DW-1:0]      r_m_beta   [MUL_LAT];
    logic [MUL_LAT-1:0] r_m_valid, r_m_last;
    logic [DW-1:0]      r_add_pipe [ADD_LAT];
    logic [ADD_LAT-1:0] r_a_valid, r_a_last;

    logic               w_wr_w, w_wr_b, w_accept, w_pix_last, w_ch_last;
    logic [PTR_W-1:0]   w_wptr_nxt, w_bptr_nxt;
    logic [DW-1:0]      w_prod, w_sum;

    assign w_wr_w     = (r_state == LOAD) && valid_weight_in && (r_wptr < PTR_W'(CHANNEL_NUM));
    assign w_wr_b     = (r_state == LOAD) && valid_bias_in && (r_bptr < PTR_W'(CHANNEL_NUM));
    assign w_wptr_nxt = r_wptr + PTR_W'(w_wr_w);
    assign w_bptr_nxt = r_bptr + PTR_W'(w_wr_b);
    assign w_accept   = (r_state == RUN) && valid_in;
    assign w_pix_last = (r_pix_cnt == PIX_W'(PIXELS_PER_CH - 1));
    assign w_ch_last  = (r_ch_cnt == CH_W'(CHANNEL_NUM - 1));
    assign w_prod     = r_mul_pipe[MUL_LAT-1];
    assign w_sum      = r_add_pipe[ADD_LAT-1];

    // Load/run FSM with coefficient pointers and channel/pixel counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LOAD;
            coef_ready <= 1'b0;
            r_wptr     <= '0;
            r_bptr     <= '0;
            r_pix_cnt  <= '0;
            r_ch_cnt   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_wptr <= w_wptr_nxt;
                    r_bptr <= w_bptr_nxt;
                    if ((w_wptr_nxt == PTR_W'(CHANNEL_NUM)) && (w_bptr_nxt == PTR_W'(CHANNEL_NUM))) begin
                        r_state    <= RUN;
                        coef_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (w_pix_last) begin
                            r_pix_cnt <= '0;
                            r_ch_cnt  <= w_ch_last ? '0 : r_ch_cnt + CH_W'(1);
                        end else begin
                            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // Coefficient arrays; never cleared, only rewritten during LOAD
    always_ff @(posedge clk) begin
        if (!reset && w_wr_w) r_gamma[r_wptr[CH_W-1:0]] <= weight_in;
        if (!reset && w_wr_b) r_beta[r_bptr[CH_W-1:0]]  <= bias_in;
    end

    // S0: capture pixel with its channel coefficients and end-of-frame flag
    always_ff @(posedge clk) begin
        r_s0_pxl   <= pxl_in;
        r_s0_gamma <= r_gamma[r_ch_cnt];
        r_s0_beta  <= r_beta[r_ch_cnt];
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
        end else begin
            r_s0_valid <= w_accept;
            r_s0_last  <= w_accept && w_pix_last && w_ch_last;
        end
    end

    // Multiply stage; beta/valid/last ride alongside the product
    always_ff @(posedge clk) begin
        r_mul_pipe[0] <= fp_mul(r_s0_pxl, r_s0_gamma);
        r_m_beta[0]   <= r_s0_beta;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            r_mul_pipe[i] <= r_mul_pipe[i-1];
            r_m_beta[i]   <= r_m_beta[i-1];
        end
        if (reset) begin
            r_m_valid <= '0;
            r_m_last  <= '0;
        end else begin
            r_m_valid[0] <= r_s0_valid;
            r_m_last[0]  <= r_s0_last;
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                r_m_valid[i] <= r_m_valid[i-1];
                r_m_last[i]  <= r_m_last[i-1];
            end
        end
    end

    // Add stage: product + beta
    always_ff @(posedge clk) begin
        r_add_pipe[0] <= fp_add(w_prod, r_m_beta[MUL_LAT-1]);
        for (int i = 1; i < int'(ADD_LAT); i++) begin
            r_add_pipe[i] <= r_add_pipe[i-1];
        end
        if (reset) begin
            r_a_valid <= '0;
            r_a_last  <= '0;
        end else begin
            r_a_valid[0] <= r_m_valid[MUL_LAT-1];
            r_a_last[0]  <= r_m_last[MUL_LAT-1];
            for (int i = 1; i < int'(ADD_LAT); i++) begin
                r_a_valid[i] <= r_a_valid[i-1];
                r_a_last[i]  <= r_a_last[i-1];
            end
        end
    end

    // Output register with optional ReLU; data holds while no result is valid
    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= r_a_valid[ADD_LAT-1];
            frame_done <= r_a_valid[ADD_LAT-1] & r_a_last[ADD_LAT-1];
            if (r_a_valid[ADD_LAT-1]) begin
                out <= (RELU_EN && w_sum[DW-1]) ? '0 : w_sum;
            end
        end
    end

endmodule

// File: doc/cnn_batch_norm_ch.md
# cnn_batch_norm_ch

Per-channel batch-normalization stage for the CNN datapath: computes out = pxl × gamma[ch] + beta[ch] in IEEE-754 floating point, with optional fused ReLU. Per-channel gamma/beta coefficients are loaded once into internal register arrays. The input pixel stream is channel-major: PIXELS_PER_CH pixels of channel 0, then channel 1, and so on. The block sits between a convolution output and the next layer's input, and is built from the existing fp_mul and fp_add units.

## Interface
- DATA_WIDTH, 32: floating-point word width, passed to fp_mul/fp_add.
- CHANNEL_NUM, 64: number of channels and depth of the gamma/beta arrays.
- PIXELS_PER_CH, 1024: pixels per channel per frame.
- MUL_LAT, 1: fp_mul pipeline depth in cycles; must match the instantiated unit.
- ADD_LAT, 1: fp_add pipeline depth in cycles; must match the instantiated unit.
- RELU_EN, 0: when 1, negative results are forced to +0.
- clk  input  1  clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  pxl_in valid this cycle.
- pxl_in  input  DATA_WIDTH  input pixel.
- valid_weight_in  input  1  weight_in valid; writes the next gamma entry.
- weight_in  input  DATA_WIDTH  gamma coefficient.
- valid_bias_in  input  1  bias_in valid; writes the next beta entry.
- bias_in  input  DATA_WIDTH  beta coefficient.
- out  output  DATA_WIDTH  normalized pixel.
- valid_out  output  1  out valid.
- coef_ready  output  1  all gamma and beta entries are loaded (state RUN).
- frame_done  output  1  one-cycle pulse, coincident with valid_out of the last pixel of the last channel.

## Operation
- States: LOAD (reset state) and RUN.
- LOAD:
  - Each valid_weight_in writes gamma[wptr] and increments wptr.
  - Each valid_bias_in writes beta[bptr] and increments bptr.
  - The two pointers are independent; simultaneous writes are both accepted.
  - Writes beyond index CHANNEL_NUM-1 are ignored.
- Transition LOAD→RUN: in the cycle after both wptr and bptr reach CHANNEL_NUM.
- RUN:
  - valid_weight_in and valid_bias_in are ignored.
  - Coefficients change only after reset.
- valid_in while in LOAD: the pixel is discarded; counters do not move; nothing is emitted.
- Counters, in RUN only:
  - pix_cnt increments on each accepted pixel.
  - At PIXELS_PER_CH-1, pix_cnt wraps to 0 and ch_cnt increments.
  - ch_cnt wraps from CHANNEL_NUM-1 to 0 with no gap or bubble.
  - Consecutive frames stream back-to-back.
- Pipeline:
  - S0 register: captures pxl_in, gamma[ch_cnt], beta[ch_cnt], valid, and last (last = pix_cnt==PIXELS_PER_CH-1 and ch_cnt==CHANNEL_NUM-1).
  - fp_mul: pxl × gamma.
  - beta and last travel through a MUL_LAT-deep shift register alongside the product.
  - fp_add: product + beta; last is delayed ADD_LAT more cycles.
  - Output register: applies ReLU when RELU_EN=1 and sign bit = 1 (out = 0).
- Arithmetic rounding, NaN, and denormal behaviour are those of fp_mul/fp_add; the block adds no width changes.
- Pipeline is fully pipelined with no backpressure. Gaps in valid_in are allowed and propagate as gaps in valid_out.

## Timing
- Latency: valid_in in cycle N produces valid_out in cycle N + MUL_LAT + ADD_LAT + 2. With defaults, this is N+4.
- Throughput: one pixel per cycle.
- coef_ready rises one cycle after the later of the two final coefficient writes.
  - A pixel presented in that same cycle is accepted.
  - A pixel presented in any earlier cycle is dropped.
- Reset values:
  - out = 0, valid_out = 0, coef_ready = 0, frame_done = 0.
  - State LOAD; wptr, bptr, pix_cnt, ch_cnt = 0.
  - All pipeline valid/last bits = 0.
  - The coefficient arrays are not cleared.
- Reset mid-stream: in-flight pixels are flushed, with no valid_out after the reset cycle. Coefficients must be reloaded.
- out holds its last value while valid_out = 0.
- frame_done is asserted only together with valid_out.

## Test plan
- Load and compute: CHANNEL_NUM=2; gamma = {0x40000000 (2.0), 0x3F800000 (1.0)}; beta = {0x3F800000 (1.0), 0x40000000 (2.0)}; pxl 0x40400000 (3.0) on channel 0 → out 0x40E00000 (7.0) exactly MUL_LAT+ADD_LAT+2 cycles later.
- Channel switch: PIXELS_PER_CH=3, CHANNEL_NUM=2, continuous stream of six pixels of 3.0 → outputs 7.0, 7.0, 7.0, 5.0 (0x40A00000), 5.0, 5.0; frame_done only with the sixth; the seventh pixel uses channel 0 again.
- ReLU: pxl 0xC0400000 (−3.0) on channel 0 → 0xC0A00000 (−5.0) with RELU_EN=0; 0x00000000 with RELU_EN=1.
- Load gating:
  - Pixels sent before coef_ready → no valid_out, counters unchanged.
  - Weights loaded before biases, with a 5-cycle gap → coef_ready rises exactly one cycle after the last bias.
  - An extra weight sent in RUN → results unchanged.
- Bubbles: valid_in pattern 1,0,1,1,0 → valid_out shows the identical pattern, shifted by the latency.
- Reset mid-stream: assert reset with 3 pixels in flight → valid_out = 0 from the next cycle, coef_ready = 0, pixels ignored until reload.
